// File: rtl/ext_pkg.sv
// Shared mode encodings and width constants for the extension unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ext_mode_t, EXT_SIGN..EXT_PASS, lane/byte/halfword widths, cfg check.
package ext_pkg;

  typedef logic [2:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN = 3'd0;
  localparam ext_mode_t EXT_ZERO = 3'd1;
  localparam ext_mode_t EXT_LUI  = 3'd2;
  localparam ext_mode_t EXT_LB   = 3'd3;
  localparam ext_mode_t EXT_LBU  = 3'd4;
  localparam ext_mode_t EXT_LH   = 3'd5;
  localparam ext_mode_t EXT_LHU  = 3'd6;
  localparam ext_mode_t EXT_PASS = 3'd7;

  localparam int EXT_MODE_W     = 3;
  localparam int EXT_BYTE_W     = 8;
  localparam int EXT_HALF_W     = 16;
  localparam int EXT_DEF_IN_W   = 16;
  localparam int EXT_DEF_OUT_W  = 32;
  localparam int EXT_DEF_LANE_W = 2;

  // Legal parameter set: 1 <= IN_W < OUT_W, OUT_W a multiple of 16,
  // LANE_W just wide enough to address every byte of the word.
  function automatic bit ext_cfg_ok(input int in_w, input int out_w, input int lane_w);
    return (in_w >= 1) && (in_w < out_w) && ((out_w % EXT_HALF_W) == 0) &&
           (lane_w == $clog2(out_w / EXT_BYTE_W));
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational mode/lane mux: immediate and load-data extension.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the outputs.
// Ports: mode, imm_in, word_in, lane in; err (misaligned halfword), value out.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int LANE_W = 2
) (
  input  ext_mode_t         mode,
  input  logic [IN_W-1:0]   imm_in,
  input  logic [OUT_W-1:0]  word_in,
  input  logic [LANE_W-1:0] lane,
  output logic              err,
  output logic [OUT_W-1:0]  value
);

  logic [LANE_W-1:0]     hlane;
  logic [EXT_BYTE_W-1:0] byte_sel;
  logic [EXT_HALF_W-1:0] half_sel;

  always_comb begin
    // Halfword select uses the lane with bit 0 cleared so the part-select
    // never runs off the top of the word; a misaligned lane is flagged anyway.
    hlane    = lane & ~LANE_W'(1);
    byte_sel = word_in[{lane, 3'b000} +: EXT_BYTE_W];
    half_sel = word_in[{hlane, 3'b000} +: EXT_HALF_W];
    err      = 1'b0;
    value    = '0;
    case (mode)
      EXT_SIGN: value = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};
      EXT_ZERO: value = {{(OUT_W-IN_W){1'b0}}, imm_in};
      EXT_LUI:  value = {imm_in, {(OUT_W-IN_W){1'b0}}};
      EXT_LB:   value = {{(OUT_W-EXT_BYTE_W){byte_sel[EXT_BYTE_W-1]}}, byte_sel};
      EXT_LBU:  value = {{(OUT_W-EXT_BYTE_W){1'b0}}, byte_sel};
      EXT_LH, EXT_LHU: begin
        if (lane[0]) begin
          err = 1'b1;
        end else if (mode == EXT_LH) begin
          value = {{(OUT_W-EXT_HALF_W){half_sel[EXT_HALF_W-1]}}, half_sel};
        end else begin
          value = {{(OUT_W-EXT_HALF_W){1'b0}}, half_sel};
        end
      end
      default:  value = word_in;
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Registered extension unit (imm sign/zero/LUI, byte/halfword load extension).
// Latency: 1 cycle from accepting edge to result.
// Backpressure: holds result while out_ready=0; optional 1-entry skid keeps throughput.
// Config macro: EXT_UNIT_SKID_EN (undefined: in_ready = !out_valid || out_ready,
//   defined: one-entry skid buffer, in_ready = !skid_full from a flop).
// Ports: clock, reset (async high), flush; in_valid/in_ready, mode, imm_in,
//   word_in, lane; out_valid/out_ready, result, out_err.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W   = EXT_DEF_IN_W,
  parameter int OUT_W  = EXT_DEF_OUT_W,
  parameter int LANE_W = EXT_DEF_LANE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  ext_mode_t         mode,
  input  logic [IN_W-1:0]   imm_in,
  input  logic [OUT_W-1:0]  word_in,
  input  logic [LANE_W-1:0] lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result,
  output logic              out_err
);

  logic             core_err;
  logic [OUT_W-1:0] core_val;
  logic             accept;

  ext_core #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .LANE_W (LANE_W)
  ) u_core (
    .mode    (mode),
    .imm_in  (imm_in),
    .word_in (word_in),
    .lane    (lane),
    .err     (core_err),
    .value   (core_val)
  );

  assign accept = in_valid && in_ready;

`ifdef EXT_UNIT_SKID_EN
  logic             skid_full;
  logic [OUT_W-1:0] skid_val;
  logic             skid_err;

  assign in_ready = !skid_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_err   <= 1'b0;
      skid_full <= 1'b0;
      skid_val  <= '0;
      skid_err  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up: the older skid entry always goes first.
      if (skid_full) begin
        result    <= skid_val;
        out_err   <= skid_err;
        out_valid <= 1'b1;
        skid_full <= accept;
        if (accept) begin
          skid_val <= core_val;
          skid_err <= core_err;
        end
      end else if (accept) begin
        result    <= core_val;
        out_err   <= core_err;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new, already-extended operand.
      skid_val  <= core_val;
      skid_err  <= core_err;
      skid_full <= 1'b1;
    end
  end
`else
  assign in_ready = !reset && (!out_valid || out_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (accept) begin
        result    <= core_val;
        out_err   <= core_err;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe: extension modes, stall/drain order,
// flush discard and asynchronous reset.
module tb_ext_unit_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mode;
  logic [15:0] imm_in;
  logic [31:0] word_in;
  logic [1:0]  lane;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_err;

  int checks = 0;
  int errors = 0;

`ifdef EXT_UNIT_SKID_EN
  localparam int EXP_EXTRA = 1;
`else
  localparam int EXP_EXTRA = 0;
`endif

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .LANE_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .imm_in    (imm_in),
    .word_in   (word_in),
    .lane      (lane),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 3'd0; imm_in = '0; word_in = '0; lane = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", out_err); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_imm();
    logic [2:0]  tm [3] = '{3'd0, 3'd2, 3'd1};
    logic [15:0] ti [3] = '{16'h8001, 16'h1234, 16'hF000};
    logic [31:0] te [3] = '{32'hFFFF8001, 32'h12340000, 32'h0000F000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode = tm[i]; imm_in = ti[i]; in_valid = 1'b1;
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL imm_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (result !== te[i]) begin errors++; $display("FAIL imm_result[%0d]: got %h expected %h", i, result, te[i]); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL imm_err[%0d]: got %b expected 0", i, out_err); end
      @(negedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load();
    logic [2:0]  tm [10] = '{3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd3, 3'd6, 3'd7, 3'd3, 3'd6};
    logic [1:0]  tl [10] = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2};
    logic [31:0] te [10] = '{32'hFFFFFF80, 32'h000000FF, 32'h00000000, 32'hFFFF80FF, 32'h00007F01,
                             32'h0000007F, 32'h00000000, 32'h80FF7F01, 32'h00000001, 32'h000080FF};
    logic        tr [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    word_in = 32'h80FF7F01;
    for (int i = 0; i < 10; i++) begin
      mode = tm[i]; lane = tl[i]; in_valid = 1'b1;
      @(posedge clock); #1;
      checks++; if (result !== te[i]) begin errors++; $display("FAIL load_result[%0d]: got %h expected %h", i, result, te[i]); end
      checks++; if (out_err !== tr[i]) begin errors++; $display("FAIL load_err[%0d]: got %b expected %b", i, out_err, tr[i]); end
      @(negedge clock);
    end
    in_valid = 1'b0; lane = '0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    logic [31:0] obs [3];
    int idx = 0;
    int n = 0;
    int extra = 0;
    logic take;
    logic fire;
    mode = 3'd7; lane = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid = (idx < 3);
      word_in = (idx < 3) ? words[idx] : 32'h0;
      #1;
      take = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (cyc >= 1 && cyc <= 3) begin
        checks++; if (out_valid !== 1'b1 || result !== words[0]) begin
          errors++; $display("FAIL b2b_hold[%0d]: got valid=%b result=%h expected valid=1 result=%h", cyc, out_valid, result, words[0]);
        end
        if (take) extra++;
      end
      if (cyc >= 2 && cyc <= 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 0", cyc, in_ready); end
      end
      if (fire && n < 3) begin obs[n] = result; n++; end
      @(posedge clock);
      if (take) idx++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    checks++; if (extra !== EXP_EXTRA) begin errors++; $display("FAIL b2b_extra_accepts: got %0d expected %0d", extra, EXP_EXTRA); end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_drain_count: got %0d expected 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (i < n && obs[i] !== words[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, obs[i], words[i]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    mode = 3'd7; lane = '0;
    out_ready = 1'b0; in_valid = 1'b1; word_in = 32'h1111_2222;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'h1111_2222) begin
      errors++; $display("FAIL flush_pre: got valid=%b result=%h expected valid=1 result=11112222", out_valid, result);
    end
    @(negedge clock);
    out_ready = 1'b1; flush = 1'b1; word_in = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost[%0d]: got valid=%b result=%h expected valid=0", i, out_valid, result); end
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset();
    mode = 3'd7; lane = '0;
    out_ready = 1'b0; in_valid = 1'b1; word_in = 32'h5A5A_A5A5;
    @(posedge clock); #1;
    @(negedge clock);
    word_in = 32'h7777_0000;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'h5A5A_A5A5) begin
      errors++; $display("FAIL areset_pre: got valid=%b result=%h expected valid=1 result=5a5aa5a5", out_valid, result);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL areset_result: got %h expected 00000000", result); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL areset_err: got %b expected 0", out_err); end
    #1 reset = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_skid_clear[%0d]: got valid=%b result=%h expected valid=0", i, out_valid, result); end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_load();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
